mmcm_div_sequencer: RTL and testbench
=====================================

Name: mmcm_div_sequencer

Overview:
- Upstream control stage for the 7-series MMCM DRP reconfiguration engine.
- Accepts a requested integer CLKOUT0 divide and CLKFBOUT multiply over a valid/ready handshake, and converts each into HIGH_TIME, LOW_TIME, EDGE and NO_COUNT counter fields.
- Holds those fields stable, pulses start_reconfig when the engine is ready, then supervises done, MMCM lock and settle time with timeouts.
- Reports completion or error to the requesting logic.

Parameters:
- DEFAULT_DIVIDE, 20, CLKOUT0 divide loaded at reset (range 1..128).
- DEFAULT_MULT, 20, CLKFBOUT multiply loaded at reset (range 2..64).
- TIMEOUT_CYCLES, 1000000, maximum clk cycles spent in any single wait state.
- SETTLE_CYCLES, 1024, clk cycles after lock before done is reported (minimum 1).

Ports:
- clk  in  1  DRP/control clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a transfer occurs when req_valid & req_ready.
- req_divide  in  8  requested CLKOUT0 divide.
- req_mult  in  7  requested CLKFBOUT multiply.
- reconfig_ready  in  1  DRP engine idle.
- reconfig_done  in  1  DRP engine finished (single-cycle pulse).
- mmcm_locked  in  1  MMCM LOCKED (already synchronous to clk).
- start_reconfig  out  1  single-cycle start pulse to the engine.
- clkout0_high_time, clkout0_low_time  out  6 each.
- clkout0_edge, clkout0_no_count  out  1 each.
- clkfbout_high_time, clkfbout_low_time  out  6 each.
- clkfbout_edge, clkfbout_no_count  out  1 each.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse on successful completion.
- err  out  1  single-cycle pulse on failure.
- err_code  out  2  0 none, 1 invalid request, 2 engine timeout, 3 lock timeout; held until the next accepted request.

Behaviour:
- Field encoding for value N: high = N>>1, low = N−high, edge = N[0], no_count = (N==1).
  - N==1 forces high = 1, low = 1, edge = 0.
  - A field value of 64 is encoded as 6'd0.
- Reset (rst_n low at a clk edge):
  - FSM goes to IDLE.
  - Field outputs are loaded with the encodings of DEFAULT_DIVIDE / DEFAULT_MULT (20 → high 10, low 10, edge 0, no_count 0).
  - start_reconfig, busy, done, err = 0; err_code = 0; timers cleared.
  - Reset mid-operation aborts immediately with no done/err pulse. The DRP engine is responsible for its own recovery.
- FSM states:
  - IDLE: req_ready = 1. On a transfer, latch the request and go to CHECK. err_code clears on the transfer.
  - CHECK (1 cycle):
    - Invalid when divide is 0 or >128, or when mult <2 or >64. On invalid: err pulse, err_code = 1, return to IDLE; field outputs unchanged.
    - Otherwise register the new field outputs and go to WAIT_READY.
  - WAIT_READY: when reconfig_ready = 1, go to START.
  - START: start_reconfig = 1 for exactly this cycle, then go to WAIT_DONE.
  - WAIT_DONE: when reconfig_done = 1, go to WAIT_LOCK.
  - WAIT_LOCK: when mmcm_locked = 1, load the settle counter and go to SETTLE.
  - SETTLE:
    - Count SETTLE_CYCLES consecutive locked cycles.
    - If lock drops, return to WAIT_LOCK; the lock timer is not reset.
    - On expiry: done pulse, go to IDLE.
- Timeouts:
  - A single timer clears on entry to each wait state and increments every cycle while waiting.
  - Reaching TIMEOUT_CYCLES in WAIT_READY or WAIT_DONE: err, code 2.
  - Reaching TIMEOUT_CYCLES in WAIT_LOCK or SETTLE: err, code 3.
  - After a timeout the FSM returns to IDLE and field outputs keep the new values.
- Field outputs change only in the CHECK cycle and never while start_reconfig is pending or running.
- done and err are never asserted in the same cycle.
- Latency: request accept → start_reconfig ≥ 3 cycles (CHECK, WAIT_READY, START).
- Timer widths are $clog2 of the respective parameter plus 1.
- No combinational path from inputs to outputs except req_ready = (state==IDLE).

Decomposition:
- Shared package mmcm_pkg holds:
  - the state enum;
  - err_code constants;
  - the field limits (64, 128);
  - a packed typedef for a counter field {high[5:0], low[5:0], edge, no_count}.
- One natural sub-module, mmcm_div_encode: purely combinational N → field struct, instantiated twice (CLKOUT0 and CLKFBOUT).

Test Plan:
- Reset → outputs 10/10/0/0 for both counters, busy = 0, req_ready = 1.
- Request divide 21, mult 20; model asserts ready, 5 cycles later done, lock held; SETTLE_CYCLES = 4 →
  - CLKOUT0 fields 10/11/edge 1;
  - one start_reconfig pulse;
  - done 4 cycles after lock.
- Request divide 1 and divide 128 →
  - divide 1: high 1, low 1, no_count 1;
  - divide 128: high 0, low 0 (64 encoding), edge 0.
- Request divide 0 or mult 65 → err pulse, err_code 1, fields unchanged, start_reconfig never asserted.
- reconfig_ready held low, TIMEOUT_CYCLES = 16 → err at 16 cycles in WAIT_READY, err_code 2.
- Lock never rises → err, err_code 3.
- Lock drops during SETTLE → re-enters WAIT_LOCK, done only after a full settle.
- rst_n low during WAIT_DONE → next cycle IDLE, no done/err, fields at defaults.

Source files
------------

// File: rtl/mmcm_div_sequencer_pkg.sv
// Shared types for the MMCM divide sequencer: FSM states, error codes,
// field limits and the counter-field bundle with its encoding function.
package mmcm_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_WAIT_READY,
      S_START,
      S_WAIT_DONE,
      S_WAIT_LOCK,
      S_SETTLE
   } state_e;

   localparam logic [1:0] ERR_NONE      = 2'd0;
   localparam logic [1:0] ERR_INVALID   = 2'd1;
   localparam logic [1:0] ERR_ENGINE_TO = 2'd2;
   localparam logic [1:0] ERR_LOCK_TO   = 2'd3;

   localparam int unsigned FIELD_MAX = 64;
   localparam int unsigned DIV_MAX   = 128;
   localparam int unsigned MULT_MIN  = 2;
   localparam int unsigned MULT_MAX  = FIELD_MAX;

   typedef struct packed {
      logic [5:0] high;
      logic [5:0] low;
      logic       edge_sel;
      logic       no_count;
   } cnt_field_t;

   // high = N>>1, low = N-high, both mod 64 so that 64 encodes as 0.
   // Working in 6 bits gives exactly that wrap for N up to 128.
   function automatic cnt_field_t encode_field(input logic [7:0] n);
      cnt_field_t f;
      f.high     = n[6:1];
      f.low      = n[5:0] - n[6:1];
      f.edge_sel = n[0];
      f.no_count = (n == 8'd1);
      if (f.no_count) begin
         f.high     = 6'd1;
         f.low      = 6'd1;
         f.edge_sel = 1'b0;
      end
      return f;
   endfunction

endpackage

// File: rtl/mmcm_div_sequencer_if.sv
// Request/status bundle between requesting logic (master) and the
// sequencer (slave): valid/ready request plus busy/done/err reporting.
interface mmcm_div_sequencer_if;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_divide;
   logic [6:0] req_mult;
   logic       busy;
   logic       done;
   logic       err;
   logic [1:0] err_code;

   modport master (
      output req_valid, req_divide, req_mult,
      input  req_ready, busy, done, err, err_code
   );

   modport slave (
      input  req_valid, req_divide, req_mult,
      output req_ready, busy, done, err, err_code
   );
endinterface

// File: rtl/mmcm_div_encode.sv
// Combinational N -> {high, low, edge, no_count} counter-field encoder.
// Ports: n_i (integer divide/multiply), field_o (encoded field).
module mmcm_div_encode
   import mmcm_pkg::*;
(
   input  logic [7:0] n_i,
   output cnt_field_t field_o
);

   always_comb begin
      field_o = encode_field(n_i);
   end

endmodule

// File: rtl/mmcm_div_sequencer.sv
// MMCM reconfiguration control: accepts divide/multiply requests, encodes
// counter fields, starts the DRP engine and supervises done, lock, settle.
// Ports: clk, rst_n, req (request/status bundle), reconfig_ready/done,
// mmcm_locked, start_reconfig, CLKOUT0/CLKFBOUT counter-field outputs.
module mmcm_div_sequencer
   import mmcm_pkg::*;
#(
   parameter int unsigned DEFAULT_DIVIDE = 20,
   parameter int unsigned DEFAULT_MULT   = 20,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned SETTLE_CYCLES  = 1024
) (
   input  logic                       clk,
   input  logic                       rst_n,
   mmcm_div_sequencer_if.slave        req,
   input  logic                       reconfig_ready,
   input  logic                       reconfig_done,
   input  logic                       mmcm_locked,
   output logic                       start_reconfig,
   output logic [5:0]                 clkout0_high_time,
   output logic [5:0]                 clkout0_low_time,
   output logic                       clkout0_edge,
   output logic                       clkout0_no_count,
   output logic [5:0]                 clkfbout_high_time,
   output logic [5:0]                 clkfbout_low_time,
   output logic                       clkfbout_edge,
   output logic                       clkfbout_no_count
);

   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam int SW = $clog2(SETTLE_CYCLES) + 1;

   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [SW-1:0] SET_LOAD = SW'(SETTLE_CYCLES);
   localparam logic [SW-1:0] SET_ONE  = SW'(1);

   localparam cnt_field_t CO_DEF = encode_field(8'(DEFAULT_DIVIDE));
   localparam cnt_field_t FB_DEF = encode_field(8'(DEFAULT_MULT));

   state_e     state_q, state_d;
   logic [7:0] div_q, div_d;
   logic [6:0] mult_q, mult_d;
   cnt_field_t co_q, co_d;
   cnt_field_t fb_q, fb_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [SW-1:0] settle_q, settle_d;
   logic       start_q, start_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic [1:0] code_q, code_d;

   cnt_field_t co_enc;
   cnt_field_t fb_enc;
   logic       req_ok;
   logic       timer_hit;

   mmcm_div_encode u_enc_co (
      .n_i     (div_q),
      .field_o (co_enc)
   );

   mmcm_div_encode u_enc_fb (
      .n_i     ({1'b0, mult_q}),
      .field_o (fb_enc)
   );

   always_comb begin
      req_ok = (div_q != 8'd0)
            && (div_q <= 8'(DIV_MAX))
            && (mult_q >= 7'(MULT_MIN))
            && (mult_q <= 7'(MULT_MAX));
      timer_hit = (timer_q >= TO_LAST);

      state_d  = state_q;
      div_d    = div_q;
      mult_d   = mult_q;
      co_d     = co_q;
      fb_d     = fb_q;
      timer_d  = timer_q;
      settle_d = settle_q;
      start_d  = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      code_d   = code_q;

      unique case (state_q)
         S_IDLE: begin
            if (req.req_valid) begin
               div_d   = req.req_divide;
               mult_d  = req.req_mult;
               code_d  = ERR_NONE;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (req_ok) begin
               co_d    = co_enc;
               fb_d    = fb_enc;
               timer_d = '0;
               state_d = S_WAIT_READY;
            end else begin
               err_d   = 1'b1;
               code_d  = ERR_INVALID;
               state_d = S_IDLE;
            end
         end
         S_WAIT_READY: begin
            if (reconfig_ready) begin
               start_d = 1'b1;
               state_d = S_START;
            end else if (timer_hit) begin
               err_d   = 1'b1;
               code_d  = ERR_ENGINE_TO;
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_START: begin
            timer_d = '0;
            state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (reconfig_done) begin
               timer_d = '0;
               state_d = S_WAIT_LOCK;
            end else if (timer_hit) begin
               err_d   = 1'b1;
               code_d  = ERR_ENGINE_TO;
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_WAIT_LOCK: begin
            // Lock timer spans WAIT_LOCK and SETTLE, so a lock
            // bounce does not restart it.
            if (mmcm_locked) begin
               settle_d = SET_LOAD;
               timer_d  = timer_q + 1'b1;
               state_d  = S_SETTLE;
            end else if (timer_hit) begin
               err_d   = 1'b1;
               code_d  = ERR_LOCK_TO;
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_SETTLE: begin
            if (mmcm_locked && settle_q == SET_ONE) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else if (timer_hit) begin
               err_d   = 1'b1;
               code_d  = ERR_LOCK_TO;
               state_d = S_IDLE;
            end else if (!mmcm_locked) begin
               timer_d = timer_q + 1'b1;
               state_d = S_WAIT_LOCK;
            end else begin
               settle_d = settle_q - 1'b1;
               timer_d  = timer_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         div_q    <= 8'(DEFAULT_DIVIDE);
         mult_q   <= 7'(DEFAULT_MULT);
         co_q     <= CO_DEF;
         fb_q     <= FB_DEF;
         timer_q  <= '0;
         settle_q <= '0;
         start_q  <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         code_q   <= ERR_NONE;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         mult_q   <= mult_d;
         co_q     <= co_d;
         fb_q     <= fb_d;
         timer_q  <= timer_d;
         settle_q <= settle_d;
         start_q  <= start_d;
         done_q   <= done_d;
         err_q    <= err_d;
         code_q   <= code_d;
      end
   end

   assign req.req_ready = (state_q == S_IDLE);
   assign req.busy      = (state_q != S_IDLE);
   assign req.done      = done_q;
   assign req.err       = err_q;
   assign req.err_code  = code_q;

   assign start_reconfig     = start_q;
   assign clkout0_high_time  = co_q.high;
   assign clkout0_low_time   = co_q.low;
   assign clkout0_edge       = co_q.edge_sel;
   assign clkout0_no_count   = co_q.no_count;
   assign clkfbout_high_time = fb_q.high;
   assign clkfbout_low_time  = fb_q.low;
   assign clkfbout_edge      = fb_q.edge_sel;
   assign clkfbout_no_count  = fb_q.no_count;

endmodule

// File: tb/tb_mmcm_div_sequencer.sv
// Self-checking bench for mmcm_div_sequencer: vector table plus
// hand sequences for timeouts, lock bounce and mid-operation reset.
module tb_mmcm_div_sequencer;

   typedef struct packed {
      logic [5:0] h;
      logic [5:0] l;
      logic       e;
      logic       n;
   } fld_t;

   typedef struct {
      logic [7:0] d;
      logic [6:0] m;
      bit         is_err;
      logic [1:0] code;
      fld_t       co;
      fld_t       fb;
   } vec_t;

   typedef struct {
      bit         is_err;
      logic [1:0] code;
      fld_t       co;
      fld_t       fb;
      int         starts;
      int         start_base;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;
   logic reconfig_ready = 1'b1;
   logic reconfig_done = 1'b0;
   logic mmcm_locked = 1'b1;
   logic start_reconfig;
   logic [5:0] co_h, co_l, fb_h, fb_l;
   logic co_e, co_n, fb_e, fb_n;

   mmcm_div_sequencer_if rq();

   mmcm_div_sequencer #(
      .DEFAULT_DIVIDE (20),
      .DEFAULT_MULT   (20),
      .TIMEOUT_CYCLES (16),
      .SETTLE_CYCLES  (4)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .req                (rq),
      .reconfig_ready     (reconfig_ready),
      .reconfig_done      (reconfig_done),
      .mmcm_locked        (mmcm_locked),
      .start_reconfig     (start_reconfig),
      .clkout0_high_time  (co_h),
      .clkout0_low_time   (co_l),
      .clkout0_edge       (co_e),
      .clkout0_no_count   (co_n),
      .clkfbout_high_time (fb_h),
      .clkfbout_low_time  (fb_l),
      .clkfbout_edge      (fb_e),
      .clkfbout_no_count  (fb_n)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   exp_t sbq[$];
   vec_t vt[9];

   // Engine / MMCM model configuration (written only by the test).
   bit cfg_ready = 1'b1;
   int cfg_done_delay = 5;
   int cfg_lock_delay = 1;
   int cfg_drop_after = 0;

   // Engine model state (written only by the model).
   int starts = 0;
   int last_rise = 0;
   int dcnt = 0;
   int lcnt = 0;
   int hcnt = 0;
   bit drop_armed = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      reconfig_done  = 1'b0;
      reconfig_ready = cfg_ready;
      if (start_reconfig) begin
         starts++;
         mmcm_locked = 1'b0;
         lcnt = 0;
         hcnt = 0;
         dcnt = cfg_done_delay;
         drop_armed = (cfg_drop_after > 0);
      end else if (dcnt > 0) begin
         dcnt--;
         if (dcnt == 0) begin
            reconfig_done = 1'b1;
            lcnt = cfg_lock_delay;
         end
      end else if (lcnt > 0) begin
         lcnt--;
         if (lcnt == 0) begin
            mmcm_locked = 1'b1;
            last_rise = cyc;
            hcnt = 0;
         end
      end else if (mmcm_locked && drop_armed) begin
         hcnt++;
         if (hcnt == cfg_drop_after) begin
            mmcm_locked = 1'b0;
            lcnt = 2;
            drop_armed = 1'b0;
         end
      end
   end

   function automatic fld_t f(input int h, input int l,
                              input bit e, input bit n);
      fld_t r;
      r.h = 6'(h);
      r.l = 6'(l);
      r.e = e;
      r.n = n;
      return r;
   endfunction

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic chk_fields(input string tag, input fld_t co,
                             input fld_t fb);
      chk({tag, "_clkout0"}, 32'({co_h, co_l, co_e, co_n}), 32'(co));
      chk({tag, "_clkfbout"}, 32'({fb_h, fb_l, fb_e, fb_n}), 32'(fb));
   endtask

   int accept_cyc = 0;

   task automatic send(input logic [7:0] d, input logic [6:0] m,
                       input exp_t e);
      @(negedge clk);
      chk("req_ready_idle", 32'(rq.req_ready), 32'd1);
      rq.req_valid  = 1'b1;
      rq.req_divide = d;
      rq.req_mult   = m;
      e.start_base  = starts;
      sbq.push_back(e);
      @(negedge clk);
      rq.req_valid = 1'b0;
      accept_cyc = cyc;
      chk("busy_after_accept", 32'(rq.busy), 32'd1);
      chk("ready_after_accept", 32'(rq.req_ready), 32'd0);
      chk("err_code_cleared", 32'(rq.err_code), 32'd0);
   endtask

   task automatic check_outcome();
      exp_t e;
      chk("done_err_exclusive", 32'(rq.done & rq.err), 32'd0);
      if (sbq.size() == 0) begin
         chk("unexpected_outcome", 32'({rq.done, rq.err}), 32'd0);
      end else begin
         e = sbq.pop_front();
         chk("outcome_is_err", 32'(rq.err), 32'(e.is_err));
         chk("err_code", 32'(rq.err_code), 32'(e.code));
         chk("start_pulses", 32'(starts - e.start_base), 32'(e.starts));
         chk_fields("fields", e.co, e.fb);
         // Lock is driven on a negedge and sampled one edge later,
         // then SETTLE_CYCLES locked edges elapse before done shows.
         if (!e.is_err)
            chk("settle_latency", 32'(cyc - last_rise), 32'd5);
      end
   endtask

   task automatic wait_outcome(input int max_cyc);
      int n = 0;
      bit got = 1'b0;
      while (!got && n < max_cyc) begin
         @(negedge clk);
         n++;
         if (rq.done || rq.err) begin
            got = 1'b1;
            check_outcome();
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL outcome_timeout waited=%0d required=done_or_err",
                  max_cyc);
         if (sbq.size() > 0) sbq.delete(0);
      end
   endtask

   function automatic exp_t mk(input bit is_err, input logic [1:0] code,
                               input fld_t co, input fld_t fb,
                               input int st);
      exp_t e;
      e.is_err = is_err;
      e.code = code;
      e.co = co;
      e.fb = fb;
      e.starts = st;
      e.start_base = 0;
      return e;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int pulses;
      int w;
      rq.req_valid  = 1'b0;
      rq.req_divide = 8'd0;
      rq.req_mult   = 7'd0;

      vt[0] = '{8'd21,  7'd20, 0, 2'd0, f(10, 11, 1, 0), f(10, 10, 0, 0)};
      vt[1] = '{8'd1,   7'd2,  0, 2'd0, f(1, 1, 0, 1),   f(1, 1, 0, 0)};
      vt[2] = '{8'd128, 7'd64, 0, 2'd0, f(0, 0, 0, 0),   f(32, 32, 0, 0)};
      vt[3] = '{8'd0,   7'd20, 1, 2'd1, f(0, 0, 0, 0),   f(32, 32, 0, 0)};
      vt[4] = '{8'd20,  7'd65, 1, 2'd1, f(0, 0, 0, 0),   f(32, 32, 0, 0)};
      vt[5] = '{8'd129, 7'd10, 1, 2'd1, f(0, 0, 0, 0),   f(32, 32, 0, 0)};
      vt[6] = '{8'd7,   7'd1,  1, 2'd1, f(0, 0, 0, 0),   f(32, 32, 0, 0)};
      vt[7] = '{8'd64,  7'd63, 0, 2'd0, f(32, 32, 0, 0), f(31, 32, 1, 0)};
      vt[8] = '{8'd127, 7'd5,  0, 2'd0, f(63, 0, 1, 0),  f(2, 3, 1, 0)};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_fields("reset", f(10, 10, 0, 0), f(10, 10, 0, 0));
      chk("reset_busy", 32'(rq.busy), 32'd0);
      chk("reset_ready", 32'(rq.req_ready), 32'd1);
      chk("reset_pulses", 32'({start_reconfig, rq.done, rq.err}), 32'd0);
      chk("reset_err_code", 32'(rq.err_code), 32'd0);

      for (int i = 0; i < 9; i++) begin
         send(vt[i].d, vt[i].m,
              mk(vt[i].is_err, vt[i].code, vt[i].co, vt[i].fb,
                 vt[i].is_err ? 0 : 1));
         wait_outcome(100);
         repeat (3) @(negedge clk);
         if (vt[i].is_err)
            chk("err_code_held", 32'(rq.err_code), 32'(vt[i].code));
      end

      // Engine never ready: timeout in WAIT_READY.
      cfg_ready = 1'b0;
      send(8'd9, 7'd9, mk(1, 2'd2, f(4, 5, 1, 0), f(4, 5, 1, 0), 0));
      wait_outcome(100);
      chk("ready_timeout_cycles", 32'(cyc - accept_cyc), 32'd17);
      cfg_ready = 1'b1;
      repeat (2) @(negedge clk);

      // Lock never returns: timeout in WAIT_LOCK.
      cfg_lock_delay = -1;
      send(8'd6, 7'd6, mk(1, 2'd3, f(3, 3, 0, 0), f(3, 3, 0, 0), 1));
      wait_outcome(100);
      cfg_lock_delay = 1;
      repeat (2) @(negedge clk);

      // Lock bounces during SETTLE: done only after a full settle.
      cfg_drop_after = 2;
      send(8'd33, 7'd12, mk(0, 2'd0, f(16, 17, 1, 0), f(6, 6, 0, 0), 1));
      wait_outcome(100);
      cfg_drop_after = 0;
      repeat (2) @(negedge clk);

      // Reset while waiting for the engine.
      cfg_done_delay = -1;
      send(8'd11, 7'd11, mk(0, 2'd0, f(5, 6, 1, 0), f(5, 6, 1, 0), 1));
      w = 0;
      while (starts == sbq[0].start_base && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("start_before_reset", 32'(starts - sbq[0].start_base), 32'd1);
      repeat (2) @(negedge clk);
      chk_fields("new_fields", f(5, 6, 1, 0), f(5, 6, 1, 0));
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      sbq.delete();
      chk("midreset_busy", 32'(rq.busy), 32'd0);
      chk("midreset_ready", 32'(rq.req_ready), 32'd1);
      chk_fields("midreset", f(10, 10, 0, 0), f(10, 10, 0, 0));
      pulses = 0;
      repeat (20) begin
         @(negedge clk);
         if (rq.done || rq.err || start_reconfig) pulses++;
      end
      chk("no_pulse_after_reset", 32'(pulses), 32'd0);
      cfg_done_delay = 5;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
